hub75_scan_driver: RTL and testbench
====================================

// Module: hub75_scan_driver
// PURPOSE
//  Parametrised LED-matrix scan driver for a dual-half (upper/lower) RGB panel. Reads the pixel framebuffer one column at a time
//  through a 1-cycle-latency read port and shifts R0/G0/B0/R1/G1/B1 out with a shift clock. It then latches each row and
//  displays it with binary-coded-modulation bit planes, giving DEPTH bits of colour per channel. Sits between the game's
//  framebuffer and the panel pins, and replaces the fixed 6-register single-bit data path.
// PARAMETERS
//  COLS      60  columns per row (>=2)
//  ROWS_HALF 16  rows per panel half; row_addr walks 0..ROWS_HALF-1
//  DEPTH     2   bits per colour channel (bit planes, >=1)
//  BASE_ON   4   display cycles for plane 0; plane p displays BASE_ON<<p cycles
// PORTS
//  clk        in  1   system clock
//  rst        in  1   synchronous active-high reset
//  enable     in  1   run scanning; sampled in IDLE
//  fb_addr    out $clog2(ROWS_HALF)+$clog2(COLS)  {row, col} read address
//  fb_rd_en   out 1   read strobe; data valid on fb_data the following cycle
//  fb_data    in  6*DEPTH  {R0,G0,B0,R1,G1,B1}, each DEPTH bits, MSB first
//  r0,g0,b0   out 1   upper-half colour bits
//  r1,g1,b1   out 1   lower-half colour bits
//  pclk       out 1   panel shift clock; panel samples on rising edge
//  lat        out 1   row latch pulse
//  oe_n       out 1   panel output enable, active low
//  row_addr   out $clog2(ROWS_HALF)  displayed row
//  frame_done out 1   one-cycle pulse at end of the last plane of the last row
//  busy       out 1   high in every state except IDLE
// BEHAVIOUR
//  - Reset: all colour outputs 0, pclk 0, lat 0, oe_n 1, row_addr 0, fb_addr 0, fb_rd_en 0, frame_done 0, busy 0.
//    Internal row, plane, col and display counters are 0; state is IDLE.
//  - FSM IDLE->PREFETCH->SHIFT->BLANK->LATCH->DISPLAY.
//    - After DISPLAY: ->PREFETCH (next plane/row) or ->IDLE.
//    - IDLE->PREFETCH when enable=1.
//  - PREFETCH (1 cycle): fb_rd_en=1, fb_addr={row,0}.
//  - SHIFT takes 2 cycles per column, so 2*COLS cycles. oe_n=1 throughout.
//    - Phase 0: pclk=0; colour outputs take bit [plane] of each channel field of fb_data.
//    - Phase 1: pclk=1; colour outputs hold. If col<COLS-1, fb_rd_en=1 and fb_addr={row,col+1}.
//  - BLANK (1 cycle): oe_n=1, pclk=0.
//  - LATCH (1 cycle): lat=1, oe_n=1; row_addr<=row.
//  - DISPLAY: lat=0; oe_n=0 for BASE_ON<<plane cycles.
//    - Plane p shown for a row costs 2*COLS+3+(BASE_ON<<p) cycles.
//    - On exit: plane increments. On plane wrap (DEPTH-1->0), row increments.
//    - On row wrap (ROWS_HALF-1->0), frame_done pulses in the last DISPLAY cycle.
//  - Colour outputs and fb_addr hold their last value outside SHIFT/PREFETCH. fb_rd_en=0 except as stated above.
//  - enable=0 mid-frame: the current DISPLAY completes, then IDLE with oe_n=1; row/plane reset to 0 and frame_done is not pulsed.
//  - enable re-asserted in the same cycle DISPLAY ends: the FSM goes to IDLE first; it never skips to PREFETCH.
//  - rst mid-operation: next cycle equals the reset state. No partial pclk high or lat pulse may persist.
//  - Counters use exact widths. Col, row and plane compare against COLS-1, ROWS_HALF-1 and DEPTH-1; no reliance on overflow.
// CONFIGURATION
//  - HUB75_BRIGHTNESS_EN defined: extra input brightness[7:0].
//    - In DISPLAY, oe_n=0 only while disp_cnt < ((BASE_ON<<plane)*brightness)>>8; oe_n=1 otherwise.
//    - DISPLAY length is unchanged. brightness is sampled at LATCH. brightness=0 means oe_n stays 1 for the whole frame.
//  - Not defined: no brightness port; oe_n=0 for the full DISPLAY window.
// TESTING  (COLS=4, ROWS_HALF=2, DEPTH=2, BASE_ON=2 unless noted)
//  - Reset, then enable=1: first PREFETCH on the following cycle.
//    - Plane-0 row costs 13 cycles, plane-1 row 15 cycles, frame 56 cycles; frame_done every 56 cycles.
//  - fb_data=12'hFFF when col=2, else 0: plane 0 shows exactly one pclk rising edge with all six colour bits =1,
//    the third edge of the row.
//  - fb_data R0 field=2'b10, rest 0: r0=0 at every plane-0 edge and r0=1 at every plane-1 edge.
//    oe_n low 2 cycles then 4 cycles.
//  - Drop enable during SHIFT of row 1: DISPLAY completes, IDLE, busy=0, no frame_done.
//    Re-enable: restart at row 0, plane 0.
//  - Assert rst during DISPLAY: next cycle oe_n=1, lat=0, pclk=0, row_addr=0, busy=0.
//  - HUB75_BRIGHTNESS_EN, brightness=128: oe_n low 1 of 2 plane-0 cycles and 2 of 4 plane-1 cycles.
//    brightness=0: oe_n never low.

Source files
------------

// File: rtl/hub75_scan_driver.sv
// HUB75 dual-half scan driver: prefetch/shift a row, latch it, then show BCM bit planes (optional HUB75_BRIGHTNESS_EN dimming).
// Row-plane time 2*COLS+3+(BASE_ON<<plane) cycles; no backpressure, fb read data is expected exactly one cycle after fb_rd_en.
module hub75_scan_driver #(
  parameter int COLS      = 60,
  parameter int ROWS_HALF = 16,
  parameter int DEPTH     = 2,
  parameter int BASE_ON   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                                brightness,
`endif
  output logic [$clog2(ROWS_HALF)+$clog2(COLS)-1:0] fb_addr,
  output logic                                      fb_rd_en,
  input  logic [6*DEPTH-1:0]                        fb_data,
  output logic                                      r0,
  output logic                                      g0,
  output logic                                      b0,
  output logic                                      r1,
  output logic                                      g1,
  output logic                                      b1,
  output logic                                      pclk,
  output logic                                      lat,
  output logic                                      oe_n,
  output logic [$clog2(ROWS_HALF)-1:0]              row_addr,
  output logic                                      frame_done,
  output logic                                      busy
);

  localparam int RW    = $clog2(ROWS_HALF);
  localparam int CW    = $clog2(COLS);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXON = BASE_ON << (DEPTH - 1);
  localparam int DW    = $clog2(MAXON + 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS_HALF - 1);
  localparam logic [PW-1:0] PLANE_LAST = PW'(DEPTH - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREFETCH = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_BLANK    = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;
  localparam logic [2:0] S_DISPLAY  = 3'd5;

  logic [2:0]         state;
  logic [CW-1:0]      col;
  logic               phase;
  logic [PW-1:0]      plane;
  logic [RW-1:0]      row;
  logic [DW-1:0]      disp_cnt;
  logic               stop_req;
  logic [5:0]         rgb_q;
  logic [RW+CW-1:0]   addr_q;
  logic [5:0]         pix;
  logic [DW-1:0]      on_len;
  logic               disp_last;
  logic               stopping;
  logic               shift_load;

  assign on_len     = DW'(BASE_ON) << plane;
  assign disp_last  = (disp_cnt == on_len - DW'(1));
  // A stop request is sticky so a late re-enable cannot skip the pass through IDLE.
  assign stopping   = stop_req | ~enable;
  assign shift_load = (state == S_SHIFT) && !phase;

  always_comb begin
    pix = '0;
    for (int k = 0; k < 6; k++) pix[k] = fb_data[k*DEPTH + int'(plane)];
  end

  assign {r0, g0, b0, r1, g1, b1} = shift_load ? pix : rgb_q;

  always_comb begin
    fb_rd_en = 1'b0;
    fb_addr  = addr_q;
    if (state == S_PREFETCH) begin
      fb_rd_en = 1'b1;
      fb_addr  = {row, {CW{1'b0}}};
    end else if (state == S_SHIFT && phase && col != COL_LAST) begin
      fb_rd_en = 1'b1;
      fb_addr  = {row, col + CW'(1)};
    end
  end

  assign pclk       = (state == S_SHIFT) && phase;
  assign lat        = (state == S_LATCH);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DISPLAY) && disp_last && (plane == PLANE_LAST) &&
                      (row == ROW_LAST) && !stopping;

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]    bright_q;
  logic [DW+7:0] on_prod;
  logic [DW-1:0] on_thr;

  assign on_prod = {8'd0, on_len} * {{DW{1'b0}}, bright_q};
  assign on_thr  = DW'(on_prod >> 8);
  assign oe_n    = !((state == S_DISPLAY) && (disp_cnt < on_thr));
`else
  assign oe_n    = (state != S_DISPLAY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= '0;
      phase    <= 1'b0;
      plane    <= '0;
      row      <= '0;
      disp_cnt <= '0;
      stop_req <= 1'b0;
      rgb_q    <= '0;
      addr_q   <= '0;
      row_addr <= '0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q <= '0;
`endif
    end else begin
      addr_q <= fb_addr;
      if (shift_load) rgb_q <= pix;
      case (state)
        S_IDLE: begin
          stop_req <= 1'b0;
          row      <= '0;
          plane    <= '0;
          if (enable) state <= S_PREFETCH;
        end
        S_PREFETCH: state <= S_SHIFT;
        S_SHIFT: begin
          phase <= ~phase;
          if (phase) begin
            if (col == COL_LAST) begin
              col   <= '0;
              state <= S_BLANK;
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_BLANK: state <= S_LATCH;
        S_LATCH: begin
          row_addr <= row;
          disp_cnt <= '0;
`ifdef HUB75_BRIGHTNESS_EN
          bright_q <= brightness;
`endif
          state    <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (disp_last) begin
            disp_cnt <= '0;
            if (stopping) begin
              state <= S_IDLE;
              row   <= '0;
              plane <= '0;
            end else begin
              state <= S_PREFETCH;
              if (plane == PLANE_LAST) begin
                plane <= '0;
                row   <= (row == ROW_LAST) ? '0 : row + RW'(1);
              end else begin
                plane <= plane + PW'(1);
              end
            end
          end else begin
            disp_cnt <= disp_cnt + DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      if (state != S_IDLE && !enable) stop_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver (COLS=4, ROWS_HALF=2, DEPTH=2, BASE_ON=2).
module tb_hub75_scan_driver;

  localparam int COLS      = 4;
  localparam int ROWS_HALF = 2;
  localparam int DEPTH     = 2;
  localparam int BASE_ON   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  fb_addr;
  logic        fb_rd_en;
  logic [11:0] fb_data = '0;
  logic        r0, g0, b0, r1, g1, b1;
  logic        pclk, lat, oe_n;
  logic [0:0]  row_addr;
  logic        frame_done, busy;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'd255;
`endif

  hub75_scan_driver #(
    .COLS(COLS), .ROWS_HALF(ROWS_HALF), .DEPTH(DEPTH), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .pclk(pclk), .lat(lat), .oe_n(oe_n), .row_addr(row_addr),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] mem [0:1][0:3];
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= mem[fb_addr[2]][fb_addr[1:0]];
    else          fb_data <= '0;
  end

  logic [5:0] exp_rgb[$];
  int         exp_row[$];
  int         exp_len[$];
  int         exp_fd[$];
  int         checks = 0;
  int         failures = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name, int act);
    checks++;
    failures++;
    $display("FAIL %s: got %0d with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops the scoreboard on every pclk rise, oe_n window end and frame_done.
  initial begin
    logic prev_pclk;
    int   run;
    prev_pclk = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pclk = 1'b0;
        run = 0;
      end else begin
        if (pclk && !prev_pclk) begin
          if (exp_rgb.size() == 0) fail_now("pclk_unexpected", int'({r0, g0, b0, r1, g1, b1}));
          else check("rgb", int'({r0, g0, b0, r1, g1, b1}), int'(exp_rgb.pop_front()));
        end
        prev_pclk = pclk;
        if (!oe_n) run++;
        else if (run > 0) begin
          if (exp_len.size() == 0) fail_now("oe_unexpected", run);
          else begin
            check("row_addr", int'(row_addr), exp_row.pop_front());
            check("oe_len", run, exp_len.pop_front());
          end
          run = 0;
        end
        if (frame_done) begin
          if (exp_fd.size() == 0) fail_now("frame_done_unexpected", cyc);
          else check("frame_done_cyc", cyc, exp_fd.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) step();
  endtask

  // Field layout {R0,G0,B0,R1,G1,B1}, two bits each, bit p selects the plane.
  function automatic logic [5:0] plane_bits(logic [11:0] w, int p);
    return {w[10+p], w[8+p], w[6+p], w[4+p], w[2+p], w[p]};
  endfunction

  function automatic int rp_cycles(int p);
    return (p == 0) ? 13 : 15;
  endfunction

  function automatic int on_cycles(int p);
    int n;
    n = (p == 0) ? 2 : 4;
`ifdef HUB75_BRIGHTNESS_EN
    n = (n * int'(brightness)) >> 8;
`endif
    return n;
  endfunction

  task automatic push_rp(int r, int p, bit with_disp);
    for (int c = 0; c < COLS; c++) exp_rgb.push_back(plane_bits(mem[r][c], p));
    if (with_disp && on_cycles(p) > 0) begin
      exp_row.push_back(r);
      exp_len.push_back(on_cycles(p));
    end
  endtask

  // Enable was raised in cycle t0; run n row-planes, dropping enable in the SHIFT of the last.
  task automatic run_seq(int t0, int n);
    int sum;
    int last_start;
    int end_c;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      push_rp((i / 2) % 2, i % 2, 1'b1);
      sum += rp_cycles(i % 2);
      if (i % 4 == 3 && i < n - 1) exp_fd.push_back(t0 + sum);
    end
    wait_until(t0 + 1);
    check("prefetch_rd_en", int'(fb_rd_en), 1);
    check("prefetch_addr", int'(fb_addr), 0);
    check("prefetch_busy", int'(busy), 1);
    last_start = t0 + 1 + sum - rp_cycles((n - 1) % 2);
    wait_until(last_start + 3);
    enable = 1'b0;
    end_c = t0 + 1 + sum;
    while (busy && cyc < end_c + 20) step();
    check("idle_cycle", cyc, end_c);
    check("idle_busy", int'(busy), 0);
    check("idle_oe_n", int'(oe_n), 1);
  endtask

  task automatic check_reset(string tag);
    check({tag, "_rgb"}, int'({r0, g0, b0, r1, g1, b1}), 0);
    check({tag, "_pclk"}, int'(pclk), 0);
    check({tag, "_lat"}, int'(lat), 0);
    check({tag, "_oe_n"}, int'(oe_n), 1);
    check({tag, "_row_addr"}, int'(row_addr), 0);
    check({tag, "_fb_addr"}, int'(fb_addr), 0);
    check({tag, "_fb_rd_en"}, int'(fb_rd_en), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic load(logic [11:0] a0, logic [11:0] a1, logic [11:0] a2, logic [11:0] a3,
                      logic [11:0] c0, logic [11:0] c1, logic [11:0] c2, logic [11:0] c3);
    mem[0][0] = a0; mem[0][1] = a1; mem[0][2] = a2; mem[0][3] = a3;
    mem[1][0] = c0; mem[1][1] = c1; mem[1][2] = c2; mem[1][3] = c3;
  endtask

  initial begin
    int t0;
    load('0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // All six bits set only at column 2: third edge of each row-plane is 6'h3F.
    load(12'h000, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'hFFF, 12'h000);
    enable = 1'b1;
    t0 = cyc;
    run_seq(t0, 9);
    step();

    // R0 field 2'b10: r0 low on plane 0, high on plane 1; drop during row 1 shift.
    load(12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800);
    enable = 1'b1;
    t0 = cyc;
    run_seq(t0, 3);
    step();

    // Distinct words per pixel catch address and bit-slice mixups; restart at row 0.
    load(12'h0F3, 12'hA5C, 12'h3C6, 12'h9E1, 12'h7B2, 12'hC48, 12'h16D, 12'h555);
    enable = 1'b1;
    t0 = cyc;
    run_seq(t0, 5);
    step();

    // Re-enable in the last DISPLAY cycle after a stop: must pass through IDLE.
    enable = 1'b1;
    t0 = cyc;
    push_rp(0, 0, 1'b1);
    wait_until(t0 + 4);
    enable = 1'b0;
    wait_until(t0 + 13);
    check("reassert_disp_busy", int'(busy), 1);
    enable = 1'b1;
    step();
    check("reassert_idle_busy", int'(busy), 0);
    run_seq(t0 + 14, 2);
    step();

    // Reset during row 1 display.
    enable = 1'b1;
    t0 = cyc;
    push_rp(0, 0, 1'b1);
    push_rp(0, 1, 1'b1);
    push_rp(1, 0, 1'b0);
    wait_until(t0 + 40);
    check("pre_rst_oe_n", int'(oe_n), 0);
    check("pre_rst_row_addr", int'(row_addr), 1);
    rst = 1'b1;
    enable = 1'b0;
    step();
    check_reset("midrst");
    rst = 1'b0;
    step();

`ifdef HUB75_BRIGHTNESS_EN
    brightness = 8'd128;
    load(12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800);
    enable = 1'b1;
    t0 = cyc;
    run_seq(t0, 3);
    step();
    brightness = 8'd0;
    enable = 1'b1;
    t0 = cyc;
    run_seq(t0, 4);
    step();
`endif

    repeat (5) step();
    check("left_rgb", exp_rgb.size(), 0);
    check("left_disp", exp_len.size(), 0);
    check("left_frame_done", exp_fd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
